strob_seq: RTL and testbench
============================

Name: strob_seq

Overview:
- Timing sequencer for the processor state-control unit.
- Generates the strob1 / strob2 / got pulse train that advances the state register.
- Stretches strob1 while a memory access awaits its ok handshake, and raises a no-memory alarm on timeout.
- Implements front-panel single-step: halts after strob1 until the step switch is pressed.

Parameters:
S1_LEN, 3, strob1 minimum high time in clk_sys cycles (>=1)
S2_LEN, 3, strob2 high time in cycles (>=1)
GAP_LEN, 1, low gap between strob1 and strob2 in cycles (>=1)
GOT_LEN, 1, got high time in cycles (>=1)
ALARM_LEN, 255, max cycles strob1 may wait for ok before alarm (>=1)

Ports:
clk_sys  in  1  system clock, all state changes on rising edge
clo  in  1  asynchronous active-high reset ("clear all")
run  in  1  level: sequencer cycles states while high
ss_long  in  1  current state needs a second strobe (strob2); sampled at end of strob1 phase
mem_op  in  1  current state is a memory access; sampled on entry to S1
ok  in  1  memory/bus acknowledge, level
mode  in  1  1 = single-step mode; sampled at end of strob1 phase
step  in  1  front-panel step switch, asynchronous level
strob1  out  1  first strobe
strob2  out  1  second strobe (long states only)
got  out  1  end-of-state strobe; state register latches on it
step_wait  out  1  high while halted awaiting a step press
alarm  out  1  one-cycle pulse: ok timeout (no memory)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (clo=1, asynchronous): FSM=IDLE; all counters, synchroniser and edge flops cleared.
  - All outputs 0 while clo is high and on release.
  - clo mid-cycle aborts immediately; no got is issued.
- Step input: 2-flop synchroniser plus rising-edge detector, giving a one-cycle step_edge.
  - Edge detection is 2 cycles latency from step; the edge is consumed only in STEPW.
- FSM states: IDLE, S1, S1W, STEPW, GAP, S2, GOT. Outputs are Moore, registered.
  - IDLE: all outputs 0. run=1 -> S1 on the next edge. Latch mem_op into mem_q.
  - S1: strob1=1 for exactly S1_LEN cycles. On the last cycle: if mem_q & !ok -> S1W; else -> END1.
  - S1W: strob1=1, wait counter increments each cycle.
    - ok=1 -> END1.
    - Counter reaches ALARM_LEN without ok -> alarm=1 for one cycle (the transition cycle), then END1 as if ok.
    - ok and timeout in the same cycle: ok wins, no alarm.
  - END1 (decision, not a state): mode=1 -> STEPW; else ss_long=1 -> GAP; else -> GOT.
  - STEPW: strob1=0, step_wait=1. step_edge -> GAP if ss_long, else GOT (ss_long sampled at exit).
    - run dropping in STEPW does not release the halt; only a step press or clo does.
  - GAP: all strobes low for GAP_LEN cycles -> S2.
  - S2: strob2=1 for S2_LEN cycles -> GOT.
  - GOT: got=1 for GOT_LEN cycles. On the last cycle: run=1 -> S1 (re-latch mem_op, no idle cycle); run=0 -> IDLE.
- run deasserted anywhere after S1 entry: the current state completes through GOT, then IDLE. No truncated strobes.
- strob1, strob2 and got are never high simultaneously. Each state cycle yields exactly one got.
- Phase counters are sized by $clog2 of the largest length parameter.
  - They reload on every phase entry. No wrap-around is visible externally.
- busy = (FSM != IDLE).

Test Plan:
- clo pulse then run=1, mem_op=0, ss_long=0, mode=0 (defaults) -> strob1 high 3 cycles, then got high 1 cycle, repeating every 4 cycles; strob2 never high.
- ss_long=1 -> per state: strob1 3, gap 1 (all low), strob2 3, got 1; period 8 cycles.
- mem_op=1, ok asserted 10 cycles after strob1 rises -> strob1 high 11 cycles total, then got; alarm stays 0.
- mem_op=1, ok held 0 with ALARM_LEN=255 -> alarm single pulse at the cycle strob1 falls; got follows, and the next state cycle starts if run=1.
- mode=1 -> after strob1, step_wait=1 and outputs hold indefinitely. Toggle step 0->1 -> got appears 3 cycles after the step edge (2 sync + 1). Holding step high gives no further advance.
- clo asserted during S2 -> strob2 drops asynchronously, busy=0, no got; after release with run=1, strob1 restarts cleanly.

Source files
------------

// File: rtl/strob_seq.sv
// strob_seq: strob1/strob2/got sequencer with ok-wait stretch, no-memory alarm and single-step halt.
module strob_seq #(
  parameter int S1_LEN    = 3,
  parameter int S2_LEN    = 3,
  parameter int GAP_LEN   = 1,
  parameter int GOT_LEN   = 1,
  parameter int ALARM_LEN = 255
) (
  input  logic clk_sys,
  input  logic clo,
  input  logic run,
  input  logic ss_long,
  input  logic mem_op,
  input  logic ok,
  input  logic mode,
  input  logic step,
  output logic strob1,
  output logic strob2,
  output logic got,
  output logic step_wait,
  output logic alarm,
  output logic busy
);
  localparam int M1 = S1_LEN > S2_LEN ? S1_LEN : S2_LEN;
  localparam int M2 = M1 > GAP_LEN ? M1 : GAP_LEN;
  localparam int M3 = M2 > GOT_LEN ? M2 : GOT_LEN;
  localparam int MAXL = M3 > ALARM_LEN ? M3 : ALARM_LEN;
  localparam int CW = MAXL > 1 ? $clog2(MAXL) : 1;

  typedef enum logic [2:0] {IDLE, S1, S1W, STEPW, GAP, S2, GOT} state_t;

  state_t state_q, state_d, end1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mem_q, mem_d, done, timeout, step_edge;
  logic [2:0] sync_q;

  // counters run down from length-1; a phase ends on the cycle the counter reads zero
  function automatic logic [CW-1:0] len_m1(input state_t s);
    return s == S1  ? CW'(S1_LEN - 1) :
           s == S1W ? CW'(ALARM_LEN - 1) :
           s == GAP ? CW'(GAP_LEN - 1) :
           s == S2  ? CW'(S2_LEN - 1) :
           s == GOT ? CW'(GOT_LEN - 1) : '0;
  endfunction

  assign done      = cnt_q == '0;
  assign timeout   = state_q == S1W && done && !ok;
  assign step_edge = sync_q[1] & ~sync_q[2];
  assign end1      = mode ? STEPW : ss_long ? GAP : GOT;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = run ? S1 : IDLE;
      S1:      state_d = done ? ((mem_q && !ok) ? S1W : end1) : S1;
      S1W:     state_d = (ok || done) ? end1 : S1W;
      STEPW:   state_d = step_edge ? (ss_long ? GAP : GOT) : STEPW;
      GAP:     state_d = done ? S2 : GAP;
      S2:      state_d = done ? GOT : S2;
      GOT:     state_d = done ? (run ? S1 : IDLE) : GOT;
      default: state_d = IDLE;
    endcase
    cnt_d = state_d != state_q ? len_m1(state_d) : done ? cnt_q : cnt_q - CW'(1);
    mem_d = (state_d == S1 && state_q != S1) ? mem_op : mem_q;
  end

  // outputs are registered from the next state so they are glitch-free Moore signals
  always_ff @(posedge clk_sys or posedge clo) begin
    if (clo) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mem_q     <= 1'b0;
      sync_q    <= '0;
      strob1    <= 1'b0;
      strob2    <= 1'b0;
      got       <= 1'b0;
      step_wait <= 1'b0;
      alarm     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_q     <= mem_d;
      sync_q    <= {sync_q[1:0], step};
      strob1    <= state_d == S1 || state_d == S1W;
      strob2    <= state_d == S2;
      got       <= state_d == GOT;
      step_wait <= state_d == STEPW;
      alarm     <= timeout;
      busy      <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_strob_seq.sv
// tb_strob_seq: randomized scoreboard bench; per state cycle the expected phase lengths are queued and checked by a monitor.
module tb_strob_seq;
  localparam int S1_LEN = 3, S2_LEN = 3, GAP_LEN = 1, GOT_LEN = 1, ALARM_LEN = 255;
  localparam int LIM = S1_LEN + ALARM_LEN;

  logic clk_sys = 1'b0, clo = 1'b1, run = 1'b0, ss_long = 1'b0, mem_op = 1'b0;
  logic ok = 1'b0, mode = 1'b0, step = 1'b0;
  logic strob1, strob2, got, step_wait, alarm, busy;
  int errs = 0, checks = 0;

  typedef struct {int s1; int sw; int gap; int s2; int got; int alarm; int idle; int order;} rec_t;
  rec_t exp_q[$];

  bit in_rec = 0;
  int last_p = 0, n_s1, n_sw, n_gap, n_s2, n_got, n_al, n_ovl, idle = 0, idle_rec, order;

  always #5 clk_sys = ~clk_sys;

  strob_seq #(.S1_LEN(S1_LEN), .S2_LEN(S2_LEN), .GAP_LEN(GAP_LEN), .GOT_LEN(GOT_LEN),
              .ALARM_LEN(ALARM_LEN)) dut (
    .clk_sys(clk_sys), .clo(clo), .run(run), .ss_long(ss_long), .mem_op(mem_op), .ok(ok),
    .mode(mode), .step(step), .strob1(strob1), .strob2(strob2), .got(got),
    .step_wait(step_wait), .alarm(alarm), .busy(busy));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic finish_rec();
    rec_t e;
    in_rec = 0;
    if (exp_q.size() == 0) begin
      chk("pending_expect", exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    chk("phase_order", order, e.order);
    chk("strob1_len", n_s1, e.s1);
    chk("step_wait_len", n_sw, e.sw);
    chk("gap_len", n_gap, e.gap);
    chk("strob2_len", n_s2, e.s2);
    chk("got_len", n_got, e.got);
    chk("alarm_pulses", n_al, e.alarm);
    chk("strobe_overlap", n_ovl, 0);
    if (e.idle >= 0) chk("idle_between", idle_rec, e.idle);
  endtask

  // monitor: phase code per cycle 1=strob1 2=step_wait 3=gap 4=strob2 5=got 0=idle
  always @(negedge clk_sys) begin
    int p;
    if (clo) begin
      in_rec = 0;
      last_p = 0;
      idle = 0;
    end else begin
      p = strob1 ? 1 : step_wait ? 2 : strob2 ? 4 : got ? 5 : busy ? 3 : 0;
      if (in_rec && last_p == 5 && p != 5) finish_rec();
      if (!in_rec && p == 1) begin
        in_rec = 1; order = 0; idle_rec = idle; idle = 0;
        n_s1 = 0; n_sw = 0; n_gap = 0; n_s2 = 0; n_got = 0; n_al = 0; n_ovl = 0;
      end
      if (in_rec) begin
        n_s1 += int'(p == 1); n_sw += int'(p == 2); n_gap += int'(p == 3);
        n_s2 += int'(p == 4); n_got += int'(p == 5); n_al += int'(alarm);
        if (int'(strob1) + int'(strob2) + int'(got) + int'(step_wait) > 1) n_ovl++;
        if (p != last_p) order = order * 8 + p;
      end else if (p == 0) idle++;
      last_p = p;
    end
  end

  // one state cycle; returns on a negedge while got is high
  task automatic run_cycle(input int mem, input int okd, input int ss, input int md, input int h,
                           input int idle_exp, input bit drop);
    rec_t e;
    int k, o;
    e.s1 = !mem ? S1_LEN : (okd + 1 < S1_LEN) ? S1_LEN : (okd + 1 > LIM) ? LIM : okd + 1;
    e.alarm = (mem != 0 && okd >= LIM) ? 1 : 0;
    e.sw = md != 0 ? h + 3 + (step ? 3 : 0) : 0;
    e.gap = ss != 0 ? GAP_LEN : 0;
    e.s2 = ss != 0 ? S2_LEN : 0;
    e.got = GOT_LEN;
    e.idle = idle_exp;
    o = 1;
    if (md != 0) o = o * 8 + 2;
    if (ss != 0) o = (o * 8 + 3) * 8 + 4;
    e.order = o * 8 + 5;
    mem_op = mem[0]; ss_long = ss[0]; mode = md[0]; ok = 1'b0;
    exp_q.push_back(e);
    k = 0;
    while (!strob1 && k < 400) begin @(negedge clk_sys); k++; end
    if (!strob1) begin chk("strob1_rise_wait", int'(strob1), 1); return; end
    if (drop) run = 1'b0;
    k = 0;
    while (strob1 && k < 600) begin
      ok = mem != 0 ? (k >= okd) : 1'($urandom);
      @(negedge clk_sys);
      k++;
    end
    ok = 1'b0;
    if (md != 0) begin
      repeat (h) @(negedge clk_sys);
      if (step) begin step = 1'b0; repeat (3) @(negedge clk_sys); end
      step = 1'b1;
    end
    k = 0;
    while (!got && k < 60) begin @(negedge clk_sys); k++; end
    if (!got) chk("got_wait", int'(got), 1);
  endtask

  initial begin
    int k, nb, r;
    repeat (3) begin
      @(negedge clk_sys);
      chk("reset_outputs", int'({strob1, strob2, got, step_wait, alarm, busy}), 0);
    end
    clo = 1'b0;
    @(negedge clk_sys);
    chk("idle_after_release", int'({strob1, strob2, got, step_wait, alarm, busy}), 0);
    run = 1'b1;
    run_cycle(0, 0, 0, 0, 0, -1, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 1, 0, 0, 0, 0);
    run_cycle(0, 0, 1, 0, 0, 0, 0);
    run_cycle(1, 10, 0, 0, 0, 0, 0);
    run_cycle(1, 999, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 1, 5, 0, 0);
    run_cycle(0, 0, 0, 1, 2, 0, 0);
    run_cycle(1, 4, 1, 1, 0, 0, 0);
    run_cycle(1, LIM - 1, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 19);
      run_cycle($urandom_range(0, 1), r == 0 ? LIM - 1 : r == 1 ? LIM : $urandom_range(0, 14),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 6), 0, 0);
    end
    mem_op = 1'b0; ss_long = 1'b1; mode = 1'b0;
    k = 0;
    while (!strob2 && k < 60) begin @(negedge clk_sys); k++; end
    chk("strob2_before_abort", int'(strob2), 1);
    clo = 1'b1;
    #1;
    chk("abort_strob2", int'(strob2), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_got", int'(got), 0);
    repeat (2) @(negedge clk_sys);
    chk("abort_hold_outputs", int'({strob1, strob2, got, step_wait, alarm, busy}), 0);
    clo = 1'b0;
    run_cycle(0, 0, 0, 0, 0, -1, 0);
    run_cycle(0, 0, 1, 0, 0, 0, 1);
    nb = 0;
    repeat (12) begin @(negedge clk_sys); nb += int'(busy); end
    chk("busy_after_run_drop", nb, 0);
    chk("pending_expect", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
